// File: rtl/d_line_step_if.sv
// Segment handshake and step-output bundle for the linear interpolator.
// The master drives the segment request and the slave returns step pulses and position.
interface d_line_step_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] Xe_abs;
  logic [W-1:0] Ye_abs;
  logic         i_Xe_sign;
  logic         i_Ye_sign;
  logic         step_en;
  logic         x_step;
  logic         y_step;
  logic         x_dir;
  logic         y_dir;
  logic         busy;
  logic         done;
  logic [W:0]   steps_left;
  logic [W+1:0] x_pos;
  logic [W+1:0] y_pos;

  modport master (
    output start, Xe_abs, Ye_abs,
    output i_Xe_sign, i_Ye_sign, step_en,
    input  x_step, y_step, x_dir, y_dir,
    input  busy, done, steps_left,
    input  x_pos, y_pos
  );

  modport slave (
    input  start, Xe_abs, Ye_abs,
    input  i_Xe_sign, i_Ye_sign, step_en,
    output x_step, y_step, x_dir, y_dir,
    output busy, done, steps_left,
    output x_pos, y_pos
  );
endinterface

// File: rtl/d_line_step.sv
// Point-by-point comparison linear interpolator.
// Emits one X or Y step per enabled cycle until the segment end point is reached.
module d_line_step #(
  parameter int W = 16
) (
  input logic         pulse_clk,
  input logic         sys_rst_l,
  d_line_step_if.slave io
);
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    OVER
  } state_t;

  localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   ONE_S = {{W{1'b0}}, 1'b1};
  localparam logic [W+1:0] ONE_P = {{(W+1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [W-1:0]        xe_q, xe_d;
  logic [W-1:0]        ye_q, ye_d;
  logic [W-1:0]        x_left_q, x_left_d;
  logic [W-1:0]        y_left_q, y_left_d;
  logic [W:0]          steps_left_q, steps_left_d;
  logic signed [W+1:0] f_q, f_d;
  logic [W+1:0]        x_pos_q, x_pos_d;
  logic [W+1:0]        y_pos_q, y_pos_d;
  logic                x_dir_q, x_dir_d;
  logic                y_dir_q, y_dir_d;
  logic                x_step_q, x_step_d;
  logic                y_step_q, y_step_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [W:0]          sum;
  logic                take_x;

  always_comb begin
    state_d      = state_q;
    xe_d         = xe_q;
    ye_d         = ye_q;
    x_left_d     = x_left_q;
    y_left_d     = y_left_q;
    steps_left_d = steps_left_q;
    f_d          = f_q;
    x_pos_d      = x_pos_q;
    y_pos_d      = y_pos_q;
    x_dir_d      = x_dir_q;
    y_dir_d      = y_dir_q;
    x_step_d     = 1'b0;
    y_step_d     = 1'b0;
    done_d       = 1'b0;
    sum          = {1'b0, xe_q} + {1'b0, ye_q};
    take_x       = ((f_q >= 0) && (x_left_q != '0))
                 || (y_left_q == '0);
    case (state_q)
      IDLE: begin
        if (io.start) begin
          xe_d    = io.Xe_abs;
          ye_d    = io.Ye_abs;
          x_dir_d = io.i_Xe_sign;
          y_dir_d = io.i_Ye_sign;
          state_d = LOAD;
        end
      end
      LOAD: begin
        f_d          = '0;
        x_pos_d      = '0;
        y_pos_d      = '0;
        x_left_d     = xe_q;
        y_left_d     = ye_q;
        steps_left_d = sum;
        state_d      = (sum == '0) ? OVER : RUN;
      end
      RUN: begin
        if (io.step_en) begin
          if (take_x) begin
            x_step_d = 1'b1;
            f_d      = f_q - $signed({2'b00, ye_q});
            x_left_d = x_left_q - ONE_W;
            x_pos_d  = x_dir_q ? x_pos_q - ONE_P
                               : x_pos_q + ONE_P;
          end else begin
            y_step_d = 1'b1;
            f_d      = f_q + $signed({2'b00, xe_q});
            y_left_d = y_left_q - ONE_W;
            y_pos_d  = y_dir_q ? y_pos_q - ONE_P
                               : y_pos_q + ONE_P;
          end
          steps_left_d = steps_left_q - ONE_S;
          if (steps_left_q == ONE_S) begin
            state_d = OVER;
          end
        end
      end
      OVER: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_q      <= IDLE;
      xe_q         <= '0;
      ye_q         <= '0;
      x_left_q     <= '0;
      y_left_q     <= '0;
      steps_left_q <= '0;
      f_q          <= '0;
      x_pos_q      <= '0;
      y_pos_q      <= '0;
      x_dir_q      <= 1'b0;
      y_dir_q      <= 1'b0;
      x_step_q     <= 1'b0;
      y_step_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      xe_q         <= xe_d;
      ye_q         <= ye_d;
      x_left_q     <= x_left_d;
      y_left_q     <= y_left_d;
      steps_left_q <= steps_left_d;
      f_q          <= f_d;
      x_pos_q      <= x_pos_d;
      y_pos_q      <= y_pos_d;
      x_dir_q      <= x_dir_d;
      y_dir_q      <= y_dir_d;
      x_step_q     <= x_step_d;
      y_step_q     <= y_step_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign io.x_step     = x_step_q;
  assign io.y_step     = y_step_q;
  assign io.x_dir      = x_dir_q;
  assign io.y_dir      = y_dir_q;
  assign io.busy       = busy_q;
  assign io.done       = done_q;
  assign io.steps_left = steps_left_q;
  assign io.x_pos      = x_pos_q;
  assign io.y_pos      = y_pos_q;
endmodule

// File: tb/tb_d_line_step.sv
// Scoreboard bench for d_line_step: a W=16 and a W=4 instance.
// Expected step/done events are queued at stimulus time and popped on DUT output.
module tb_d_line_step;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  d_line_step_if #(.W(16)) ia ();
  d_line_step_if #(.W(4))  ib ();

  d_line_step #(.W(16)) u_a (
    .pulse_clk (clk),
    .sys_rst_l (rst_n),
    .io        (ia.slave)
  );

  d_line_step #(.W(4)) u_b (
    .pulse_clk (clk),
    .sys_rst_l (rst_n),
    .io        (ib.slave)
  );

  typedef struct {
    int kind;
    int xp;
    int yp;
    int sl;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  sel = 0;
  int  npulse = 0;
  logic en_s = 1'b0;

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push_seg(int xe, int ye, int xs, int ys);
    int f, xl, yl, xp, yp, n;
    ev_t e;
    f = 0; xl = xe; yl = ye; xp = 0; yp = 0;
    n = xe + ye;
    for (int i = 0; i < n; i++) begin
      if ((f >= 0 && xl != 0) || yl == 0) begin
        f -= ye; xl--;
        xp += (xs != 0) ? -1 : 1;
        e.kind = 0;
      end else begin
        f += xe; yl--;
        yp += (ys != 0) ? -1 : 1;
        e.kind = 1;
      end
      e.xp = xp; e.yp = yp; e.sl = n - i - 1;
      sb.push_back(e);
    end
    e.kind = 2; e.xp = xp; e.yp = yp; e.sl = 0;
    sb.push_back(e);
  endtask

  task automatic set_in(int st, int xe, int ye, int xs, int ys);
    if (sel == 0) begin
      ia.start = st[0]; ia.Xe_abs = xe[15:0]; ia.Ye_abs = ye[15:0];
      ia.i_Xe_sign = xs[0]; ia.i_Ye_sign = ys[0];
    end else begin
      ib.start = st[0]; ib.Xe_abs = xe[3:0]; ib.Ye_abs = ye[3:0];
      ib.i_Xe_sign = xs[0]; ib.i_Ye_sign = ys[0];
    end
  endtask

  task automatic set_start(int st);
    if (sel == 0) ia.start = st[0];
    else ib.start = st[0];
  endtask

  task automatic set_en(int v);
    if (sel == 0) ia.step_en = v[0];
    else ib.step_en = v[0];
  endtask

  function automatic int g_done();
    return (sel == 0) ? int'(ia.done) : int'(ib.done);
  endfunction

  function automatic int g_busy();
    return (sel == 0) ? int'(ia.busy) : int'(ib.busy);
  endfunction

  always @(posedge clk) begin
    en_s = (sel == 0) ? ia.step_en : ib.step_en;
  end

  task automatic pop_cmp(int kind, int xp, int yp, int sl);
    ev_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", kind, -1);
    end else begin
      e = sb.pop_front();
      chk("kind", kind, e.kind);
      chk("x_pos", xp, e.xp);
      chk("y_pos", yp, e.yp);
      chk("steps_left", sl, e.sl);
    end
  endtask

  always @(negedge clk) begin
    int xs, ys, dn, bz, xp, yp, sl;
    if (rst_n) begin
      if (sel == 0) begin
        xs = ia.x_step; ys = ia.y_step; dn = ia.done; bz = ia.busy;
        xp = int'($signed(ia.x_pos)); yp = int'($signed(ia.y_pos));
        sl = int'(ia.steps_left);
      end else begin
        xs = ib.x_step; ys = ib.y_step; dn = ib.done; bz = ib.busy;
        xp = int'($signed(ib.x_pos)); yp = int'($signed(ib.y_pos));
        sl = int'(ib.steps_left);
      end
      if (xs != 0 && ys != 0) chk("both_steps", 1, 0);
      if (xs != 0 || ys != 0) begin
        npulse++;
        if (!en_s) chk("step_without_en", 0, 1);
        pop_cmp((xs != 0) ? 0 : 1, xp, yp, sl);
      end
      if (dn != 0) begin
        chk("busy_at_done", bz, 0);
        pop_cmp(2, xp, yp, sl);
      end
    end
  end

  // mode 0: step_en held high; mode 1: step_en toggles, start re-pulsed mid-run
  task automatic run_seg(int xe, int ye, int xs, int ys,
                         int mode, output int dc);
    @(negedge clk);
    set_in(1, xe, ye, xs, ys);
    set_en(1);
    push_seg(xe, ye, xs, ys);
    dc = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        set_start(0);
        chk("busy_edge1", g_busy(), 1);
      end
      if (mode == 1) begin
        set_en(k % 2);
        if (k == 6) set_in(1, 9, 1, 1, 1);
        if (k == 7) set_start(0);
      end
      if (g_done() != 0) begin
        dc = k;
        break;
      end
    end
    if (dc < 0) chk("done_timeout", 0, 1);
    set_en(0);
    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    chk("busy_after", g_busy(), 0);
  endtask

  initial begin
    int dc;
    int cnt;
    sel = 0;
    ia.start = 0; ia.Xe_abs = 0; ia.Ye_abs = 0;
    ia.i_Xe_sign = 0; ia.i_Ye_sign = 0; ia.step_en = 0;
    ib.start = 0; ib.Xe_abs = 0; ib.Ye_abs = 0;
    ib.i_Xe_sign = 0; ib.i_Ye_sign = 0; ib.step_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", ia.busy, 0);
    chk("rst_done", ia.done, 0);
    chk("rst_xstep", ia.x_step, 0);
    chk("rst_steps_left", int'(ia.steps_left), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    npulse = 0;
    run_seg(3, 2, 0, 0, 0, dc);
    chk("done_cyc_3_2", dc, 8);
    chk("pulses_3_2", npulse, 5);

    npulse = 0;
    run_seg(0, 4, 0, 1, 0, dc);
    chk("done_cyc_0_4", dc, 7);
    chk("y_dir_0_4", ia.y_dir, 1);
    chk("pulses_0_4", npulse, 4);

    npulse = 0;
    run_seg(0, 0, 0, 0, 0, dc);
    chk("done_cyc_0_0", dc, 3);
    chk("pulses_0_0", npulse, 0);

    npulse = 0;
    run_seg(5, 5, 1, 0, 1, dc);
    chk("pulses_5_5", npulse, 10);
    chk("x_dir_5_5", ia.x_dir, 1);

    sel = 1;
    npulse = 0;
    run_seg(15, 15, 0, 0, 0, dc);
    chk("done_cyc_w4", dc, 33);
    chk("pulses_w4", npulse, 30);
    sel = 0;

    @(negedge clk);
    set_in(1, 6, 3, 0, 0);
    set_en(1);
    push_seg(6, 3, 0, 0);
    cnt = 0;
    for (int k = 1; k <= 50 && cnt < 2; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) set_start(0);
      if (ia.x_step || ia.y_step) cnt++;
    end
    chk("pulses_before_rst", cnt, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", ia.busy, 0);
    chk("mid_rst_xstep", ia.x_step, 0);
    chk("mid_rst_ystep", ia.y_step, 0);
    chk("mid_rst_xdir", ia.x_dir, 0);
    chk("mid_rst_steps_left", int'(ia.steps_left), 0);
    chk("mid_rst_x_pos", int'(ia.x_pos), 0);
    chk("mid_rst_y_pos", int'(ia.y_pos), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;

    npulse = 0;
    run_seg(6, 3, 0, 0, 0, dc);
    chk("done_cyc_6_3", dc, 12);
    chk("pulses_6_3", npulse, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
